// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: widths, funct3 codes, FSM states.
package rv32m_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned MAG_W = XLEN + 1;
  localparam int unsigned ACC_W = 2 * XLEN;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequential mul/div datapath.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : mul -> {partial high, multiplier being consumed}; div -> low half holds dividend/quotient
//   rem      : partial remainder (div only)
//   opnd     : mul -> multiplicand magnitude; div -> divisor magnitude
//   acc_nxt, rem_nxt : values after this iteration
module muldiv_step
  import rv32m_pkg::*;
(
  input  logic             is_div,
  input  logic [ACC_W-1:0] acc,
  input  logic [XLEN-1:0]  rem,
  input  logic [MAG_W-1:0] opnd,
  output logic [ACC_W-1:0] acc_nxt,
  output logic [XLEN-1:0]  rem_nxt
);

  logic [MAG_W-1:0] sum_c;
  logic [MAG_W-1:0] shifted_c;
  logic [MAG_W:0]   trial_c;

  always_comb begin
    // Multiply: conditionally add multiplicand into the high half, then shift right.
    sum_c     = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? opnd : MAG_W'(0));
    // Divide: bring in the next dividend bit and try subtracting the divisor.
    shifted_c = {rem, acc[XLEN-1]};
    trial_c   = {1'b0, shifted_c} - {1'b0, opnd};

    acc_nxt = {sum_c, acc[XLEN-1:1]};
    rem_nxt = rem;
    if (is_div) begin
      // A borrow out of the trial means the divisor did not fit: restore.
      if (!trial_c[MAG_W]) begin
        rem_nxt = trial_c[XLEN-1:0];
        acc_nxt = {acc[ACC_W-1:XLEN], acc[XLEN-2:0], 1'b1};
      end else begin
        rem_nxt = shifted_c[XLEN-1:0];
        acc_nxt = {acc[ACC_W-1:XLEN], acc[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake, fixed 33-cycle latency.
//   clk, reset (async, active-high)
//   start     : request, accepted only in IDLE or DONE
//   funct3    : 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   alu_inp1  : rs1 operand (multiplicand / dividend)
//   alu_inp2  : operand-2 (multiplier / divisor)
//   busy      : high while iterating
//   done      : one-cycle pulse when result is updated
//   result    : registered result, held until overwritten by the next op
module alu_muldiv_seq
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_inp1,
  input  logic [XLEN-1:0] alu_inp2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [ACC_W-1:0] acc;
  logic [XLEN-1:0]  rem;
  logic [MAG_W-1:0] opnd;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             a_sgn_c, b_sgn_c, sa_c, sb_c;
  logic [MAG_W-1:0] abs_a_c, abs_b_c;
  logic [ACC_W-1:0] step_acc_c, prod_s_c;
  logic [XLEN-1:0]  step_rem_c, quot_s_c, rem_s_c, res_c;

  // Operand signedness and magnitudes, evaluated at the accepting edge.
  always_comb begin
    a_sgn_c = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
              (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn_c = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
              (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa_c    = a_sgn_c & alu_inp1[XLEN-1];
    sb_c    = b_sgn_c & alu_inp2[XLEN-1];
    // Sign-extend to 33 bits before negating so 0x80000000 yields +2^31.
    abs_a_c = sa_c ? (MAG_W'(0) - {alu_inp1[XLEN-1], alu_inp1}) : {1'b0, alu_inp1};
    abs_b_c = sb_c ? (MAG_W'(0) - {alu_inp2[XLEN-1], alu_inp2}) : {1'b0, alu_inp2};
  end

  muldiv_step u_step (
    .is_div  (op[2]),
    .acc     (acc),
    .rem     (rem),
    .opnd    (opnd),
    .acc_nxt (step_acc_c),
    .rem_nxt (step_rem_c)
  );

  // Sign fix-up and result selection from the final iteration's outputs.
  always_comb begin
    prod_s_c = neg_q ? (ACC_W'(0) - step_acc_c) : step_acc_c;
    quot_s_c = neg_q ? (XLEN'(0) - step_acc_c[XLEN-1:0]) : step_acc_c[XLEN-1:0];
    rem_s_c  = neg_r ? (XLEN'(0) - step_rem_c) : step_rem_c;
    case (op)
      F3_MUL:                      res_c = prod_s_c[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_c = prod_s_c[ACC_W-1:XLEN];
      F3_DIV, F3_DIVU:             res_c = div_zero ? '1 : quot_s_c;
      default:                     res_c = rem_s_c;
    endcase
  end

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op       <= '0;
      acc      <= '0;
      rem      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_BUSY;
            busy     <= 1'b1;
            cnt      <= '0;
            op       <= funct3;
            rem      <= '0;
            opnd     <= funct3[2] ? abs_b_c : abs_a_c;
            acc      <= {XLEN'(0), funct3[2] ? abs_a_c[XLEN-1:0] : abs_b_c[XLEN-1:0]};
            neg_q    <= sa_c ^ sb_c;
            neg_r    <= sa_c;
            div_zero <= (alu_inp2 == '0);
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          acc <= step_acc_c;
          rem <= step_rem_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_c;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
